mac_engine: RTL and testbench
=============================

MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter DATA_W, default 8: operand width for a_in and b_in.
REQ-002 Parameter ACC_W, default 16: accumulator and result width.
REQ-003 Parameter K, default 3: terms per dot product.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  a_in/b_in hold a valid term this cycle.
REQ-007 a_in  input  DATA_W  unsigned operand from the sequencing fsm.
REQ-008 b_in  input  DATA_W  unsigned operand from the sequencing fsm.
REQ-009 clear  input  1  abort the current dot product and flush the pipeline.
REQ-010 mac_out  output  ACC_W  last completed dot-product result.
REQ-011 mac_valid  output  1  one-cycle pulse when mac_out updates.
REQ-012 mac_ovf  output  1  saturation flag for the result on mac_out.
REQ-013 busy  output  1  a dot product is in progress or a term is in flight.

Function
REQ-014 Stage 1 SHALL register the product a_in*b_in (ACC_W bits, unsigned) together with a product-valid bit on every cycle where enable=1.
REQ-015 Stage 2 SHALL load the product into the accumulator when the term counter is 0, and SHALL add it to the accumulator otherwise.
REQ-016 A sum exceeding 2^ACC_W-1 SHALL saturate to all ones and set a sticky overflow bit for the current dot product.
REQ-017 The term counter SHALL run 0..K-1, advance on each accumulated term, and wrap to 0 after the K-th term.
REQ-018 On the K-th term, the final sum SHALL be written to mac_out and mac_ovf, and mac_valid SHALL assert.
REQ-019 Latency: the enable of the K-th term at cycle t SHALL produce mac_valid=1 at t+2, with mac_valid high for exactly one cycle.
REQ-020 mac_out and mac_ovf SHALL hold their values until the next completed result.
REQ-021 The state machine SHALL use states IDLE and ACCUM.
REQ-022 IDLE->ACCUM SHALL occur on the first accumulated term.
REQ-023 ACCUM->IDLE SHALL occur on the K-th term or on clear.
REQ-024 With K=1, each accumulated term SHALL complete a result directly and the state SHALL remain IDLE.
REQ-025 Gaps in enable SHALL stall accumulation without loss of the partial sum.
REQ-026 Back-to-back dot products SHALL be supported: the first term of the next product may be enabled the cycle after the last term of the current product, with no bubble and no cross-contamination.
REQ-027 When clear=1, the engine SHALL drop the stage-1 product, zero the counter and the overflow bit, go to IDLE, and leave mac_out unchanged.
REQ-028 When clear and enable are asserted together, clear SHALL win and the term SHALL be discarded.
REQ-029 busy SHALL equal (state==ACCUM) OR the stage-1 product-valid bit.

Reset
REQ-030 On reset, mac_out SHALL be 0, mac_valid 0, mac_ovf 0 and busy 0.
REQ-031 On reset, the state SHALL be IDLE, the counter and accumulator 0, and the pipeline valid bits 0.
REQ-032 Reset mid-operation SHALL discard all partial state, and the first term after reset SHALL start a new dot product.

Structure
REQ-033 Package mac_pkg SHALL hold the defaults for DATA_W, ACC_W and K, plus the state enum {IDLE, ACCUM}.
REQ-034 The stage-1 multiply register SHALL be a sub-module, mac_mult_reg (operands in, registered product and valid out, with reset and flush inputs).
REQ-035 The saturating adder, term counter and FSM SHALL live in mac_engine.

Verification
REQ-036 K=3 accumulation: terms (2,3),(4,5),(6,7) on consecutive cycles -> mac_valid two cycles after the third enable, mac_out=68, mac_ovf=0.
REQ-037 Stalled input: the same terms with 2-cycle gaps between enables -> mac_out=68, with exactly one mac_valid pulse.
REQ-038 Saturation: (255,255) x3 (true sum 195075) -> mac_out=0xFFFF, mac_ovf=1; the next product (1,1) x3 -> mac_out=3, mac_ovf=0.
REQ-039 Back-to-back: products (1,2)x3 then (3,3)x3 with no gap -> mac_valid pulses 3 cycles apart, carrying mac_out=6 then 27.
REQ-040 Clear: two terms of (9,9), then clear together with a third enable, then (1,1) x3 -> a single mac_valid with mac_out=3, and mac_out unchanged through the clear.
REQ-041 Reset mid-op: reset after one term of (5,5), then (2,2) x3 -> all outputs 0 during reset, then mac_out=12.

Source files
------------

// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg -- shared defaults and state encoding for the MAC engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 16;
  localparam int MAC_K      = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_e;

endpackage

`default_nettype wire

// File: rtl/mac_mult_reg.sv
// ============================================================================
// mac_mult_reg -- stage-1 registered unsigned product with a valid bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_mult_reg #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  prod_o,
  output logic              vld_o
);

  logic [ACC_W-1:0] prod_q;
  logic             vld_q;
  logic [ACC_W-1:0] w_prod;

  // Product is taken modulo 2^ACC_W; resizing the operands first is exact for that.
  assign w_prod = ACC_W'(a_i) * ACC_W'(b_i);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) begin
        prod_q <= w_prod;
      end
    end
  end

  assign prod_o = prod_q;
  assign vld_o  = vld_q;

endmodule

`default_nettype wire

// File: rtl/mac_engine.sv
// ============================================================================
// mac_engine -- two-stage K-term unsigned dot-product engine with saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_engine
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int K      = MAC_K
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              clear,
  output logic [ACC_W-1:0]  mac_out,
  output logic              mac_valid,
  output logic              mac_ovf,
  output logic              busy
);

  localparam int               CNT_W    = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_ACCUM = ACCUM;

  logic [ACC_W-1:0] w_prod;
  logic             w_prod_vld;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             out_ovf_q, out_ovf_d;
  logic             valid_q, valid_d;

  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_sat;
  logic             w_ovf_new;

  mac_mult_reg #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clear),
    .en_i    (enable),
    .a_i     (a_in),
    .b_i     (b_in),
    .prod_o  (w_prod),
    .vld_o   (w_prod_vld)
  );

  // The first term of a product loads rather than adds, so no separate clear of acc is needed.
  always_comb begin
    w_base    = (cnt_q == '0) ? '0 : acc_q;
    w_sum     = {1'b0, w_base} + {1'b0, w_prod};
    w_sat     = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    w_ovf_new = ((cnt_q != '0) && ovf_q) || w_sum[ACC_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    valid_d   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (w_prod_vld) begin
      if (cnt_q == LAST_CNT) begin
        out_d     = w_sat;
        out_ovf_d = w_ovf_new;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
        cnt_d     = '0;
        acc_d     = w_sat;
        ovf_d     = 1'b0;
      end else begin
        state_d = ST_ACCUM;
        cnt_d   = cnt_q + CNT_W'(1);
        acc_d   = w_sat;
        ovf_d   = w_ovf_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign mac_out   = out_q;
  assign mac_ovf   = out_ovf_q;
  assign mac_valid = valid_q;
  assign busy      = (state_q == ST_ACCUM) || w_prod_vld;

endmodule

`default_nettype wire

// File: tb/tb_mac_engine.sv
// ============================================================================
// tb_mac_engine -- directed table, corner sequences and random run for mac_engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K      = 3;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              clear;
  logic [ACC_W-1:0]  mac_out;
  logic              mac_valid;
  logic              mac_ovf;
  logic              busy;

  mac_engine #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .K      (K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .a_in      (a_in),
    .b_in      (b_in),
    .clear     (clear),
    .mac_out   (mac_out),
    .mac_valid (mac_valid),
    .mac_ovf   (mac_ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: true (unsaturated) running sum over the terms of the current product.
  int m_sum = 0;
  int m_n   = 0;
  bit m_pend = 1'b0;
  int m_pval = 0;
  int m_out = 0;
  bit m_ovf = 1'b0;
  bit m_valid = 1'b0;
  bit m_busy = 1'b0;

  int vcount = 0;
  int vouts[$];
  int vcycs[$];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit c, input int a, input int b);
    if (r) begin
      m_sum = 0; m_n = 0; m_pend = 0; m_out = 0; m_ovf = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (c) begin
        m_sum = 0; m_n = 0;
      end else if (m_pend) begin
        m_sum += m_pval;
        m_n++;
        if (m_n == K) begin
          m_valid = 1;
          m_ovf   = (m_sum > MAXV);
          m_out   = m_ovf ? MAXV : m_sum;
          m_sum   = 0;
          m_n     = 0;
        end
      end
      m_pend = e && !c;
      m_pval = (a * b) % (MAXV + 1);
    end
    m_busy = (m_n != 0) || m_pend;
  endtask

  task automatic step(input bit r, input bit e, input bit c, input int a, input int b);
    reset  = r;
    enable = e;
    clear  = c;
    a_in   = a[DATA_W-1:0];
    b_in   = b[DATA_W-1:0];
    @(posedge clk);
    model_edge(r, e, c, a, b);
    @(negedge clk);
    cyc++;
    chk("model_valid", int'(mac_valid), int'(m_valid));
    chk("model_out",   int'(mac_out),   m_out);
    chk("model_ovf",   int'(mac_ovf),   int'(m_ovf));
    chk("model_busy",  int'(busy),      int'(m_busy));
    if (mac_valid) begin
      vcount++;
      vouts.push_back(int'(mac_out));
      vcycs.push_back(cyc);
    end
  endtask

  typedef struct {
    bit rst; bit en; bit clr; int a; int b;
    bit ev; int eo; bit eovf; bit eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit en, bit clr, int a, int b,
                              bit ev, int eo, bit eovf, bit eb);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.a = a; v.b = b;
    v.ev = ev; v.eo = eo; v.eovf = eovf; v.eb = eb;
    return v;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; a_in = '0; b_in = '0;

    // Reset, then a plain K=3 product
    tbl.push_back(mk(1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,1,0,2,3,     0,0,0,1));
    tbl.push_back(mk(0,1,0,4,5,     0,0,0,1));
    tbl.push_back(mk(0,1,0,6,7,     0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,     1,68,0,0));
    tbl.push_back(mk(0,0,0,0,0,     0,68,0,0));
    // Saturation then recovery
    tbl.push_back(mk(0,1,0,255,255, 0,68,0,1));
    tbl.push_back(mk(0,1,0,255,255, 0,68,0,1));
    tbl.push_back(mk(0,1,0,255,255, 0,68,0,1));
    tbl.push_back(mk(0,0,0,0,0,     1,16'hFFFF,1,0));
    tbl.push_back(mk(0,0,0,0,0,     0,16'hFFFF,1,0));
    tbl.push_back(mk(0,1,0,1,1,     0,16'hFFFF,1,1));
    tbl.push_back(mk(0,1,0,1,1,     0,16'hFFFF,1,1));
    tbl.push_back(mk(0,1,0,1,1,     0,16'hFFFF,1,1));
    tbl.push_back(mk(0,0,0,0,0,     1,3,0,0));
    // Reset mid-operation
    tbl.push_back(mk(0,1,0,5,5,     0,3,0,1));
    tbl.push_back(mk(1,0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,1,0,2,2,     0,0,0,1));
    tbl.push_back(mk(0,1,0,2,2,     0,0,0,1));
    tbl.push_back(mk(0,1,0,2,2,     0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,     1,12,0,0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].a, tbl[i].b);
      chk("tbl_valid", int'(mac_valid), int'(tbl[i].ev));
      chk("tbl_out",   int'(mac_out),   tbl[i].eo);
      chk("tbl_ovf",   int'(mac_ovf),   int'(tbl[i].eovf));
      chk("tbl_busy",  int'(busy),      int'(tbl[i].eb));
    end

    // Stalled input: two idle cycles between enables
    vcount = 0; vouts.delete();
    step(0,1,0,2,3); step(0,0,0,0,0); step(0,0,0,0,0);
    step(0,1,0,4,5); step(0,0,0,0,0); step(0,0,0,0,0);
    step(0,1,0,6,7);
    for (int i = 0; i < 4; i++) step(0,0,0,0,0);
    chk("stall_pulses", vcount, 1);
    chk("stall_out", (vouts.size() > 0) ? vouts[0] : -1, 68);

    // Back-to-back products with no bubble
    vcount = 0; vouts.delete(); vcycs.delete();
    for (int i = 0; i < 3; i++) step(0,1,0,1,2);
    for (int i = 0; i < 3; i++) step(0,1,0,3,3);
    for (int i = 0; i < 4; i++) step(0,0,0,0,0);
    chk("b2b_pulses", vcount, 2);
    if (vcount == 2) begin
      chk("b2b_spacing", vcycs[1] - vcycs[0], 3);
      chk("b2b_out0", vouts[0], 6);
      chk("b2b_out1", vouts[1], 27);
    end

    // Clear wins over a simultaneous enable and leaves mac_out alone
    vcount = 0; vouts.delete();
    step(0,1,0,9,9); step(0,1,0,9,9);
    step(0,1,1,9,9);
    chk("clr_hold_out", int'(mac_out), 27);
    chk("clr_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) step(0,1,0,1,1);
    for (int i = 0; i < 3; i++) step(0,0,0,0,0);
    chk("clr_pulses", vcount, 1);
    chk("clr_out", (vouts.size() > 0) ? vouts[0] : -1, 3);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r, e, c;
      int a, b;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      e = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(200, 255);
        b = $urandom_range(200, 255);
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
      end
      step(r, e, c, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
